// File: rtl/dac_frame_driver.sv
// dac_frame_driver: accepts channel samples on valid/ready and shifts 32-bit
// AD56x8-class command frames MSB-first with its own active-low frame strobe.
// Latency: accept at edge N -> syncDAC low with frame bit 31 at edge N+1,
// bit 0 at edge N+32, syncDAC high at edge N+33.
// Backpressure: sampleReady is high only in IDLE; one frame per 33+SYNC_GAP
// cycles.
// Optional feature macro DAC_LDAC_SYNC_EN: data frames write the input register
// only, and a one-cycle ldac low pulse follows any sample marked sampleLast.
// The internal-reference power-up frame goes out after every reset.

module dac_frame_driver #(
  parameter int DATA_WIDTH    = 12,
  parameter int NUM_CHANNELS  = 8,
  parameter int CH_WIDTH      = 3,
  parameter int POWERUP_DELAY = 4,
  parameter int SYNC_GAP      = 2
) (
  input  logic                  dacSerialClock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] sampleData,
  input  logic [CH_WIDTH-1:0]   sampleChannel,
  input  logic                  sampleLast,
  input  logic                  sampleValid,
  output logic                  sampleReady,
  output logic                  chanError,
  output logic                  syncDAC,
  output logic                  dIn,
  output logic                  ldac
);

  // FSM encoding
  localparam logic [1:0] ST_PWR_WAIT = 2'd0;
  localparam logic [1:0] ST_IDLE     = 2'd1;
  localparam logic [1:0] ST_SHIFT    = 2'd2;
  localparam logic [1:0] ST_GAP      = 2'd3;

  localparam int FRAME_BITS = 32;

  // One counter serves both the power-up wait and the bit position in SHIFT,
  // so it must hold both 32 and POWERUP_DELAY-1.
  localparam int PD_BITS = $clog2(POWERUP_DELAY + 1);
  localparam int CW      = (PD_BITS > 6) ? PD_BITS : 6;
  localparam int GW      = $clog2(SYNC_GAP + 1);

  localparam logic [CW-1:0] CNT_PWR_LAST  = CW'(POWERUP_DELAY - 1);
  localparam logic [CW-1:0] CNT_FRAME_END = CW'(FRAME_BITS);
  localparam logic [GW-1:0] GAP_LAST      = GW'(SYNC_GAP - 1);
  // The frame-end edge already counts as the first high cycle of the gap.
  // With SYNC_GAP=1 that edge only lands in GAP when an ldac pulse is pending,
  // which then needs exactly one more cycle.
  localparam logic [GW-1:0] GAP_FRAME_START = (SYNC_GAP > 1) ? GW'(1) : '0;

  localparam logic [31:0] PWRUP_FRAME = 32'h0800_0001;

`ifdef DAC_LDAC_SYNC_EN
  localparam logic [3:0] DATA_CMD  = 4'b0000;
  localparam logic       LDAC_IDLE = 1'b1;
`else
  localparam logic [3:0] DATA_CMD  = 4'b0011;
  localparam logic       LDAC_IDLE = 1'b0;
`endif

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [31:0]   sr_q, sr_d;
  logic          ready_q, ready_d;
  logic          err_q, err_d;
  logic          sync_q, sync_d;
  logic          din_q, din_d;
  logic          ldac_q, ldac_d;
  logic          pend_q, pend_d;

  logic          last_in;
  logic          chan_ok;
  logic [3:0]    addr_field;
  logic [15:0]   data_field;
  logic [31:0]   data_frame;

`ifdef DAC_LDAC_SYNC_EN
  assign last_in = sampleLast;
`else
  // Without the ldac feature the group marker has no effect.
  logic unused_last;
  assign unused_last = sampleLast;
  assign last_in     = 1'b0;
`endif

  // Frame assembly from the live inputs; only used on the accept edge, so the
  // shift register holds its own copy for the rest of the frame.
  always_comb begin
    chan_ok    = (32'(sampleChannel) < 32'(NUM_CHANNELS));
    addr_field = {1'b0, 3'(sampleChannel)};
    data_field = 16'(sampleData) << (16 - DATA_WIDTH);
    data_frame = {4'b0000, DATA_CMD, addr_field, data_field, 4'b0000};
  end

  // Next-state and output computation for the frame sequencer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    sr_d    = sr_q;
    ready_d = ready_q;
    err_d   = 1'b0;
    sync_d  = sync_q;
    din_d   = din_q;
    pend_d  = pend_q;
    ldac_d  = LDAC_IDLE;

    case (state_q)
      ST_PWR_WAIT: begin
        ready_d = 1'b0;
        sync_d  = 1'b1;
        din_d   = 1'b0;
        if (cnt_q == CNT_PWR_LAST) begin
          sr_d    = PWRUP_FRAME;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_IDLE: begin
        ready_d = 1'b1;
        if (sampleValid && ready_q) begin
          ready_d = 1'b0;
          pend_d  = last_in;
          if (chan_ok) begin
            sr_d    = data_frame;
            cnt_d   = '0;
            state_d = ST_SHIFT;
          end else begin
            // Rejected sample: report it and pace the next accept as a gap.
            err_d   = 1'b1;
            gap_d   = '0;
            state_d = ST_GAP;
          end
        end
      end

      ST_SHIFT: begin
        if (cnt_q == CNT_FRAME_END) begin
          sync_d = 1'b1;
          din_d  = 1'b0;
          if ((SYNC_GAP == 1) && !pend_q) begin
            ready_d = 1'b1;
            state_d = ST_IDLE;
          end else begin
            gap_d   = GAP_FRAME_START;
            state_d = ST_GAP;
          end
        end else begin
          sync_d = 1'b0;
          din_d  = sr_q[31];
          sr_d   = {sr_q[30:0], 1'b0};
          cnt_d  = cnt_q + 1'b1;
        end
      end

      ST_GAP: begin
        sync_d = 1'b1;
        din_d  = 1'b0;
        // A pending group end fires on the first GAP edge; the strobe is
        // already high again before the next frame can pull syncDAC low.
        if (pend_q) begin
          ldac_d = 1'b0;
          pend_d = 1'b0;
        end
        if (gap_q == GAP_LAST) begin
          ready_d = 1'b1;
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_PWR_WAIT;
        cnt_d   = '0;
      end
    endcase
  end

  // State and output registers with synchronous reset into the power-up wait.
  always_ff @(posedge dacSerialClock) begin
    if (reset) begin
      state_q <= ST_PWR_WAIT;
      cnt_q   <= '0;
      gap_q   <= '0;
      sr_q    <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      sync_q  <= 1'b1;
      din_q   <= 1'b0;
      ldac_q  <= LDAC_IDLE;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      sr_q    <= sr_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      sync_q  <= sync_d;
      din_q   <= din_d;
      ldac_q  <= ldac_d;
      pend_q  <= pend_d;
    end
  end

  assign sampleReady = ready_q;
  assign chanError   = err_q;
  assign syncDAC     = sync_q;
  assign dIn         = din_q;
  assign ldac        = ldac_q;

endmodule

// File: tb/tb_dac_frame_driver.sv
// Directed and randomized bench for dac_frame_driver: frames are rebuilt from
// the field layout with plain arithmetic and compared bit-serially, with
// strobe timing, channel rejection, reset abort and ldac pulses checked.
`timescale 1ns/1ps

module tb_dac_frame_driver;

  localparam int DW  = 12;
  localparam int NCH = 6;
  localparam int CHW = 3;
  localparam int PD  = 4;
  localparam int SG  = 2;

`ifdef DAC_LDAC_SYNC_EN
  localparam bit LDAC_MODE = 1'b1;
`else
  localparam bit LDAC_MODE = 1'b0;
`endif
  localparam int   DCMD          = LDAC_MODE ? 0 : 3;
  localparam logic LDAC_IDLE_EXP = LDAC_MODE ? 1'b1 : 1'b0;

  logic           clk = 1'b0;
  logic           reset;
  logic [DW-1:0]  sampleData;
  logic [CHW-1:0] sampleChannel;
  logic           sampleLast;
  logic           sampleValid;
  logic           sampleReady;
  logic           chanError;
  logic           syncDAC;
  logic           dIn;
  logic           ldac;

  dac_frame_driver #(
    .DATA_WIDTH(DW), .NUM_CHANNELS(NCH), .CH_WIDTH(CHW),
    .POWERUP_DELAY(PD), .SYNC_GAP(SG)
  ) dut (
    .dacSerialClock(clk), .reset(reset), .sampleData(sampleData),
    .sampleChannel(sampleChannel), .sampleLast(sampleLast),
    .sampleValid(sampleValid), .sampleReady(sampleReady),
    .chanError(chanError), .syncDAC(syncDAC), .dIn(dIn), .ldac(ldac)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_assert = 0;
  int n_fail   = 0;

  // Edges after which ldac was away from its idle level.
  int ldac_ev[$];
  always @(posedge clk) begin
    #2;
    if (ldac !== LDAC_IDLE_EXP) ldac_ev.push_back(cyc);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference frame: fields placed by weight.
  function automatic logic [31:0] exp_frame(input int ch, input int data);
    int v;
    v = DCMD * 16777216 + ch * 1048576 + data * (1 << (20 - DW));
    return 32'(v);
  endfunction

  task automatic wait_ready(input string tag, output int r);
    int w = 0;
    while (sampleReady !== 1'b1 && w < 200) begin
      tick();
      w++;
    end
    check({tag, "_rdy_seen"}, 32'(w < 200), 32'd1);
    r = cyc;
  endtask

  // Waits for the strobe, collects 32 bits, checks the strobe shape.
  task automatic recv_frame(input string tag, input logic [31:0] exp,
                            output int s, output int e);
    int          w = 0;
    logic [31:0] f = '0;
    bit          low_ok = 1'b1;
    bit          rdy_ok = 1'b1;
    while (syncDAC !== 1'b0 && w < 300) begin
      tick();
      w++;
    end
    check({tag, "_sync_seen"}, 32'(w < 300), 32'd1);
    s = cyc;
    for (int i = 0; i < 32; i++) begin
      f = {f[30:0], dIn};
      if (syncDAC !== 1'b0) low_ok = 1'b0;
      if (sampleReady !== 1'b0) rdy_ok = 1'b0;
      tick();
    end
    e = cyc;
    check({tag, "_frame"}, f, exp);
    check({tag, "_sync_low32"}, 32'(low_ok), 32'd1);
    check({tag, "_rdy_low"}, 32'(rdy_ok), 32'd1);
    check({tag, "_end_sync"}, 32'(syncDAC), 32'd1);
    check({tag, "_end_din"}, 32'(dIn), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, e, r, a, rel, w;
    int d[3];
    int s_prev;
    int exp_n;
    int errs, sync_low;

    reset = 1'b1;
    sampleData = '0;
    sampleChannel = '0;
    sampleLast = 1'b0;
    sampleValid = 1'b0;

    // Reset state
    repeat (3) tick();
    check("rst_sync", 32'(syncDAC), 32'd1);
    check("rst_din", 32'(dIn), 32'd0);
    check("rst_ready", 32'(sampleReady), 32'd0);
    check("rst_err", 32'(chanError), 32'd0);
    check("rst_ldac", 32'(ldac), 32'(LDAC_IDLE_EXP));

    // Power-up frame
    reset = 1'b0;
    rel = cyc;
    recv_frame("pwrup", 32'h0800_0001, s, e);
    check("pwrup_delay", 32'((s - rel) >= PD && (s - rel) <= PD + 1), 32'd1);
    wait_ready("pwrup", r);
    check("pwrup_gap", 32'(r - e), 32'(SG - 1));

    // Single write ch2 0xABC; inputs scrambled after the accept edge
    sampleChannel = 3'd2;
    sampleData = DW'(12'hABC);
    sampleValid = 1'b1;
    tick();
    a = cyc;
    sampleValid = 1'b0;
    sampleData = DW'($urandom);
    sampleChannel = CHW'($urandom);
    recv_frame("single", exp_frame(2, 'hABC), s, e);
    check("single_latency", 32'(s - a), 32'd1);

    // Back-to-back on channels 0,1,2 with sampleValid held high
    for (int i = 0; i < 3; i++) d[i] = int'($urandom_range(0, (1 << DW) - 1));
    sampleChannel = 3'd0;
    sampleData = DW'(d[0]);
    sampleValid = 1'b1;
    s_prev = 0;
    for (int i = 0; i < 3; i++) begin
      wait_ready("b2b", r);
      tick();
      a = cyc;
      if (i < 2) begin
        sampleChannel = CHW'(i + 1);
        sampleData = DW'(d[i + 1]);
      end else begin
        sampleValid = 1'b0;
      end
      recv_frame($sformatf("b2b%0d", i), exp_frame(i, d[i]), s, e);
      check($sformatf("b2b%0d_latency", i), 32'(s - a), 32'd1);
      if (i > 0) check($sformatf("b2b%0d_period", i), 32'(s - s_prev), 32'(33 + SG));
      s_prev = s;
    end
    check("ldac_quiet", 32'(ldac_ev.size()), 32'd0);

    // Highest valid channel
    wait_ready("ch5", r);
    d[0] = int'($urandom_range(0, (1 << DW) - 1));
    sampleChannel = CHW'(NCH - 1);
    sampleData = DW'(d[0]);
    sampleValid = 1'b1;
    tick();
    sampleValid = 1'b0;
    recv_frame("ch5", exp_frame(NCH - 1, d[0]), s, e);

    // Out-of-range channels; 7 carries sampleLast
    for (int bc = NCH; bc <= 7; bc++) begin
      ldac_ev.delete();
      wait_ready("bad", r);
      sampleChannel = CHW'(bc);
      sampleLast = (bc == 7);
      sampleData = DW'($urandom);
      sampleValid = 1'b1;
      tick();
      a = cyc;
      sampleValid = 1'b0;
      sampleLast = 1'b0;
      check($sformatf("bad%0d_err", bc), 32'(chanError), 32'd1);
      check($sformatf("bad%0d_rdy", bc), 32'(sampleReady), 32'd0);
      errs = 0;
      sync_low = (syncDAC !== 1'b1) ? 1 : 0;
      w = 0;
      do begin
        tick();
        w++;
        if (chanError !== 1'b0) errs++;
        if (syncDAC !== 1'b1) sync_low++;
      end while (sampleReady !== 1'b1 && w < 50);
      tick();
      check($sformatf("bad%0d_err_1cyc", bc), 32'(errs), 32'd0);
      check($sformatf("bad%0d_sync_high", bc), 32'(sync_low), 32'd0);
      check($sformatf("bad%0d_rdy_back", bc), 32'(cyc - 1 - a), 32'(SG));
      exp_n = (LDAC_MODE && bc == 7) ? 1 : 0;
      check($sformatf("bad%0d_ldac_n", bc), 32'(ldac_ev.size()), 32'(exp_n));
      if (ldac_ev.size() > 0)
        check($sformatf("bad%0d_ldac_at", bc), 32'(ldac_ev[0]), 32'(a + 1));
    end

    // Update group: ch0=0x123 last=0, ch1=0x456 last=1
    ldac_ev.delete();
    wait_ready("grp0", r);
    sampleChannel = 3'd0;
    sampleData = DW'(12'h123);
    sampleLast = 1'b0;
    sampleValid = 1'b1;
    tick();
    sampleValid = 1'b0;
    recv_frame("grp0", exp_frame(0, 'h123), s, e);
    repeat (2) tick();
    check("grp0_no_ldac", 32'(ldac_ev.size()), 32'd0);
    wait_ready("grp1", r);
    sampleChannel = 3'd1;
    sampleData = DW'(12'h456);
    sampleLast = 1'b1;
    sampleValid = 1'b1;
    tick();
    sampleValid = 1'b0;
    sampleLast = 1'b0;
    recv_frame("grp1", exp_frame(1, 'h456), s, e);
    wait_ready("grp1", r);
    check("grp1_gap", 32'(r - e), 32'(SG - 1));
    repeat (3) tick();
    exp_n = LDAC_MODE ? 1 : 0;
    check("grp1_ldac_n", 32'(ldac_ev.size()), 32'(exp_n));
    if (ldac_ev.size() > 0) check("grp1_ldac_at", 32'(ldac_ev[0]), 32'(e + 1));

    // Reset during a frame, sample waiting across the reset
    d[0] = int'($urandom_range(0, NCH - 1));
    d[1] = int'($urandom_range(0, (1 << DW) - 1));
    sampleChannel = CHW'(d[0]);
    sampleData = DW'(d[1]);
    sampleValid = 1'b1;
    tick();
    sampleValid = 1'b0;
    w = 0;
    while (syncDAC !== 1'b0 && w < 50) begin
      tick();
      w++;
    end
    check("mid_sync_seen", 32'(w < 50), 32'd1);
    repeat (10) tick();
    reset = 1'b1;
    d[2] = int'($urandom_range(0, (1 << DW) - 1));
    sampleChannel = 3'd3;
    sampleData = DW'(d[2]);
    sampleValid = 1'b1;
    tick();
    check("mid_rst_sync", 32'(syncDAC), 32'd1);
    check("mid_rst_din", 32'(dIn), 32'd0);
    check("mid_rst_rdy", 32'(sampleReady), 32'd0);
    tick();
    reset = 1'b0;
    recv_frame("mid_pwrup", 32'h0800_0001, s, e);
    wait_ready("mid", r);
    tick();
    sampleValid = 1'b0;
    recv_frame("mid_data", exp_frame(3, d[2]), s, e);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/dac_frame_driver.md
Name: dac_frame_driver

Overview:
- Parametrised successor to the single-channel serial DAC shifter.
- Accepts samples over a valid/ready handshake for up to 8 channels and generates its own frame strobe.
- Shifts 32-bit command frames (4 pad, 4 command, 4 address, 16 data field, 4 pad) MSB-first to an AD56x8-class DAC.
- Sits between the gain stage and the DAC pins.
- Sends the internal-reference power-up frame automatically after every reset.

Parameters:
- DATA_WIDTH, 12, sample width (1..16); left-justified in frame bits 19..(20-DATA_WIDTH); the remaining low bits are 0.
- NUM_CHANNELS, 8, number of valid DAC channels (1..8).
- CH_WIDTH, 3, width of the channel select input.
- POWERUP_DELAY, 4, cycles after reset release before the power-up frame starts (>=1).
- SYNC_GAP, 2, minimum cycles syncDAC stays high between frames (>=1).

Ports:
- dacSerialClock  in  1  serial clock; all logic on posedge; the DAC samples dIn on the falling edge.
- reset  in  1  synchronous, active-high.
- sampleData  in  DATA_WIDTH  sample to send.
- sampleChannel  in  CH_WIDTH  target channel address.
- sampleLast  in  1  marks the last sample of an update group (used only with the optional feature).
- sampleValid  in  1  sample present.
- sampleReady  out  1  block can accept a sample.
- chanError  out  1  one-cycle pulse when an out-of-range channel is accepted.
- syncDAC  out  1  active-low frame strobe.
- dIn  out  1  serial data.
- ldac  out  1  DAC load strobe, active-low.

Behaviour:
- Clock and reset: one clock (dacSerialClock); reset is synchronous and active-high.
- Reset values: syncDAC=1, dIn=0, sampleReady=0, chanError=0, ldac=0 (1 with the optional feature).
  - State goes to PWR_WAIT with the counter cleared.
  - Reset asserted mid-frame: syncDAC=1 at the next edge, the frame is aborted, and the power-up sequence repeats.
- All outputs are registered.
- States:
  - PWR_WAIT: counts POWERUP_DELAY cycles, then goes to SHIFT with frame 0x08000001 (command 1000, internal reference on).
  - IDLE: sampleReady=1. On sampleValid&&sampleReady at edge N, latches data, channel and last. sampleReady=0 from edge N.
    - If channel < NUM_CHANNELS: go to SHIFT.
    - Otherwise: chanError=1 for one cycle (edge N), no frame, go to GAP.
  - SHIFT: syncDAC=0 and dIn=frame bit 31 at edge N+1; bit 31-k at edge N+1+k.
    - Bit 0 is presented at edge N+32.
    - At edge N+33: syncDAC=1, dIn=0, go to GAP.
  - GAP: holds syncDAC=1 for SYNC_GAP cycles total, then IDLE (sampleReady=1).
    - The earliest next accept is edge N+33+SYNC_GAP.
- Data frame layout:
  - bits 31..28 = 0.
  - bits 27..24 = command 0011 (write and update channel).
  - bits 23..20 = {0, channel} zero-extended.
  - data field as above.
  - bits 3..0 = 0.
- Throughput: sampleValid held high gives exactly one frame per 33+SYNC_GAP cycles. No sample is lost or duplicated.
- sampleData and sampleChannel may change after the accept edge without affecting the frame in flight.
- Without the optional feature, ldac is held 0 permanently, so the DAC updates at the end of each frame.

Optional Feature:
- Macro: DAC_LDAC_SYNC_EN.
- Defined:
  - Data frames use command 0000 (write input register only).
  - ldac resets to 1.
  - After a frame whose latched sampleLast=1 completes (edge N+33), ldac=0 for exactly one cycle at edge N+34, then returns to 1. This gives a simultaneous update of all channels.
  - The pulse falls inside GAP. GAP is extended so that syncDAC stays high for at least 1 cycle after ldac returns high.
  - An out-of-range sample with sampleLast=1 still produces the ldac pulse, one cycle after chanError.
- Undefined:
  - sampleLast is ignored.
  - Command 0011 is used and ldac=0 constantly.
- The power-up frame is identical in both builds.

Test Plan:
- Power-up: reset 3 cycles, release; POWERUP_DELAY=4 -> sampleReady=0, syncDAC low 32 cycles shifting 0x08000001, then sampleReady=1 after SYNC_GAP.
- Single write: channel 2, data 0xABC -> dIn serialises 0x032ABC00 MSB-first while syncDAC=0 for exactly 32 cycles; ldac stays 0.
- Back-to-back: sampleValid held high with channels 0,1,2 -> three frames, each 33+SYNC_GAP=35 cycles apart, addresses 0,1,2 in order.
- Bad channel: NUM_CHANNELS=6, channel 7 -> chanError pulse 1 cycle, syncDAC stays 1, sampleReady returns after SYNC_GAP.
- Reset mid-frame: assert reset at frame bit 10 -> next edge syncDAC=1, dIn=0; after release the power-up frame is resent before any data frame.
- DAC_LDAC_SYNC_EN: writes ch0=0x123 (last=0) and ch1=0x456 (last=1) -> frames 0x00012300 and 0x00145600; single ldac low pulse 1 cycle after the second frame ends; no pulse after the first.
